data_bus: RTL
=============

Name: data_bus

Overview:
- Sits directly downstream of the CPU core's data-memory port (ram_addr/ram_data/ram_we/ram_sel/ram_ce) and returns ram_data_i to it.
- Decodes each access to one of two targets: on-chip data RAM with byte-lane writes, or a small MMIO window holding a 32-bit timer with compare/IRQ and a GPIO register pair.
- The core samples read data in its MEM stage in the same cycle, so reads are combinational and writes commit on the clock edge.

Parameters:
- RAM_AW, 10, word-address width of data RAM (depth = 2^RAM_AW words, 4 KiB default)
- GPIO_W, 8, width of GPIO in/out
- MMIO_BASE, 32'h1000_0000, base of MMIO window; addr[31:28] compared against MMIO_BASE[31:28]

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ce_i  in  4  chip enable from core; access valid when any bit set
- we_i  in  1  write enable
- addr_i  in  32  byte address, word-aligned (addr[1:0] ignored)
- sel_i  in  4  byte lanes; sel[3] = data[31:24] (big-endian)
- data_i  in  32  write data
- data_o  out  32  read data, combinational
- gpio_i  in  GPIO_W  external inputs, asynchronous
- gpio_o  out  GPIO_W  external outputs, registered
- irq_o  out  1  timer interrupt, level

Behaviour:
- Interface: one clock domain clk; rst is synchronous and active-high.
- Decode: addr[31:28] == MMIO_BASE[31:28] selects MMIO; all other addresses select RAM. RAM word index = addr[RAM_AW+1:2]; higher bits alias.
- RAM write: at posedge, when ce valid and we_i=1, each lane with sel bit set is written; other lanes are kept. RAM contents are not cleared by rst.
- Read: when ce valid and we_i=0, data_o = selected word (all 32 bits, regardless of sel). Otherwise data_o = 0. Unmapped MMIO offsets read 0.
- MMIO writes take effect only when sel_i == 4'b1111. Partial writes are ignored.
- MMIO map (offset = addr[7:0]; bits 27:8 ignored):
  - 0x00 COUNT: R/W
  - 0x04 CMP: R/W
  - 0x08 CTRL: bit0 en, bit1 irq_en, bit2 autoreload; other bits read 0
  - 0x0C STAT: bit0 match flag, write-1-to-clear
  - 0x10 GPIO_OUT: R/W
  - 0x14 GPIO_IN: RO, zero-extended
- Timer, each cycle with en=1:
  - if COUNT == CMP: flag <= 1, and COUNT <= autoreload ? 0 : COUNT+1
  - else COUNT <= COUNT+1
  - COUNT wraps 32'hFFFF_FFFF -> 0.
  - With en=0, COUNT holds and no match is detected.
- Simultaneous events:
  - Software write to COUNT overrides increment/reload in that cycle.
  - A match in the same cycle as a W1C of STAT leaves flag = 1 (set wins).
  - Writing CTRL takes effect from the next cycle.
- irq_o = flag & irq_en (combinational from registers).
- GPIO_IN: two-flop synchronizer; a read returns the second-stage value, so latency from gpio_i change to visibility is 2 cycles.
- Reset values:
  - COUNT = 0, CMP = 32'hFFFF_FFFF, CTRL = 0, flag = 0
  - GPIO_OUT = 0, synchronizer flops = 0
  - irq_o = 0, gpio_o = 0
- rst asserted mid-operation: all registers reset at that edge; any write presented in the same cycle is dropped (RAM included).

Decomposition:
- Shared defines file (alongside defines.v): MMIO offset constants (COUNT/CMP/CTRL/STAT/GPIO_OUT/GPIO_IN), CTRL bit indices, MMIO_BASE nibble.
- One natural sub-module, data_bus_timer: COUNT/CMP/CTRL/flag plus match/reload logic. It takes a decoded write strobe, offset and data, and returns read data and irq.
- RAM array and GPIO stay in the top.

Test Plan:
- RAM byte lanes: write 32'h1122_3344 sel=1111 to 0x100, then write 32'hAABB_CCDD sel=0100 to 0x100; read 0x100 -> 32'h11BB_3344. Read with ce=0 -> 0.
- Timer match/autoreload: CMP=5, CTRL=3'b111. After 6 enabled cycles COUNT reads 0, STAT=1, irq_o=1. Write STAT=1 -> irq_o=0 next cycle. Second match after 6 more cycles.
- Wrap and no-autoreload: COUNT=32'hFFFF_FFFE, CMP=32'hFFFF_FFFF, CTRL=3'b001. Two cycles later COUNT=0, flag=1, irq_o=0 (irq_en=0).
- Collisions:
  - W1C of STAT in the same cycle as a match -> flag stays 1.
  - COUNT write of 32'h40 in the same cycle as an increment -> reads 32'h40 next cycle.
- MMIO partial write: GPIO_OUT write 32'hFF with sel=0011 -> gpio_o stays 0. With sel=1111 -> gpio_o=8'hFF. Read of offset 0x20 -> 0.
- GPIO_IN and reset: gpio_i=8'h5A -> read 0x14 returns 0 for 2 cycles, then 32'h5A. Assert rst with a pending write to CMP -> CMP=32'hFFFF_FFFF, gpio_o=0, irq_o=0.

Source files
------------

// File: rtl/data_bus_pkg.sv
// -----------------------------------------------------------------------------
// data_bus_pkg
// Shared constants and types for the data-memory bus: MMIO register offsets,
// timer CTRL bit layout, the MMIO window nibble and a small decode helper.
// Imported by data_bus and data_bus_timer.
// -----------------------------------------------------------------------------
package data_bus_pkg;

  // MMIO register offsets (addr[7:0] inside the MMIO window)
  localparam logic [7:0] OFF_COUNT    = 8'h00;
  localparam logic [7:0] OFF_CMP      = 8'h04;
  localparam logic [7:0] OFF_CTRL     = 8'h08;
  localparam logic [7:0] OFF_STAT     = 8'h0C;
  localparam logic [7:0] OFF_GPIO_OUT = 8'h10;
  localparam logic [7:0] OFF_GPIO_IN  = 8'h14;

  // CTRL bit indices
  localparam int CTRL_EN_BIT         = 0;
  localparam int CTRL_IRQ_EN_BIT     = 1;
  localparam int CTRL_AUTORELOAD_BIT = 2;
  localparam int CTRL_W              = 3;

  // STAT bit index of the match flag
  localparam int STAT_FLAG_BIT = 0;

  // Upper address nibble that selects the MMIO window
  localparam logic [3:0] MMIO_NIBBLE = 4'h1;

  // Timer reset values
  localparam logic [31:0] COUNT_RESET = 32'h0000_0000;
  localparam logic [31:0] CMP_RESET   = 32'hFFFF_FFFF;

  // CTRL register; field order matches the bit indices above
  typedef struct packed {
    logic autoreload;  // bit 2
    logic irq_en;      // bit 1
    logic en;          // bit 0
  } ctrl_t;

  // Decoded target of the current access
  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_RAM  = 2'd1,
    TGT_MMIO = 2'd2
  } target_e;

  // True when the byte address falls in the MMIO window
  function automatic logic addr_is_mmio(input logic [31:0] addr,
                                        input logic [3:0]  base_nibble);
    return addr[31:28] == base_nibble;
  endfunction

endpackage

// File: rtl/data_bus_if.sv
// -----------------------------------------------------------------------------
// data_bus_if
// Core data-memory port as seen by the data bus.
//   ce_i   [3:0]  chip enable, access valid when any bit set
//   we_i          write enable
//   addr_i [31:0] byte address (word aligned, addr[1:0] ignored)
//   sel_i  [3:0]  byte lanes, sel_i[3] = data[31:24]
//   data_i [31:0] write data
//   data_o [31:0] read data, combinational
// master = core side, slave = data bus side.
// -----------------------------------------------------------------------------
interface data_bus_if;

  logic [3:0]  ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output ce_i,
    output we_i,
    output addr_i,
    output sel_i,
    output data_i,
    input  data_o
  );

  modport slave (
    input  ce_i,
    input  we_i,
    input  addr_i,
    input  sel_i,
    input  data_i,
    output data_o
  );

endinterface

// File: rtl/data_bus_timer.sv
// -----------------------------------------------------------------------------
// data_bus_timer
// 32-bit free-running timer with compare, match flag and level interrupt.
//   clk, rst      clock, synchronous active-high reset
//   wr_en         full-word MMIO write strobe (already decoded and lane-checked)
//   offset [7:0]  MMIO register offset of the current access
//   wdata  [31:0] write data
//   rdata  [31:0] read data for COUNT/CMP/CTRL/STAT, 0 for any other offset
//   irq           flag & irq_en
// -----------------------------------------------------------------------------
module data_bus_timer
  import data_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  offset,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [31:0] count_reg, count_next;
  logic [31:0] cmp_reg, cmp_next;
  ctrl_t       ctrl_reg, ctrl_next;
  logic        flag_reg, flag_next;
  logic        match;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= COUNT_RESET;
      cmp_reg   <= CMP_RESET;
      ctrl_reg  <= '0;
      flag_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      cmp_reg   <= cmp_next;
      ctrl_reg  <= ctrl_next;
      flag_reg  <= flag_next;
    end
  end

  always_comb begin
    count_next = count_reg;
    cmp_next   = cmp_reg;
    ctrl_next  = ctrl_reg;
    flag_next  = flag_reg;

    // Compare is only meaningful while counting
    match = ctrl_reg.en && (count_reg == cmp_reg);

    // Counting; the +1 wraps naturally at 32 bits
    if (ctrl_reg.en) begin
      count_next = (match && ctrl_reg.autoreload) ? COUNT_RESET : count_reg + 32'd1;
    end

    // W1C first, so a match in the same cycle below sets it again
    if (wr_en && (offset == OFF_STAT) && wdata[STAT_FLAG_BIT]) begin
      flag_next = 1'b0;
    end
    if (match) begin
      flag_next = 1'b1;
    end

    // Software writes override the counter update; CTRL is only
    // consulted from the register, so a new value acts next cycle
    if (wr_en) begin
      case (offset)
        OFF_COUNT: count_next = wdata;
        OFF_CMP:   cmp_next   = wdata;
        OFF_CTRL:  ctrl_next  = ctrl_t'(wdata[CTRL_W-1:0]);
        default:   ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_COUNT: rdata = count_reg;
      OFF_CMP:   rdata = cmp_reg;
      OFF_CTRL:  rdata[CTRL_W-1:0] = ctrl_reg;
      OFF_STAT:  rdata[STAT_FLAG_BIT] = flag_reg;
      default:   rdata = '0;
    endcase
  end

  assign irq = flag_reg & ctrl_reg.irq_en;

endmodule

// File: rtl/data_bus.sv
// -----------------------------------------------------------------------------
// data_bus
// Decodes core data-memory accesses to on-chip RAM (byte-lane writes) or the
// MMIO window (timer + GPIO). Reads are combinational so the core can sample
// them in its MEM stage; writes commit on the clock edge.
//   clk, rst         clock, synchronous active-high reset
//   bus (slave)      core data port: ce_i, we_i, addr_i, sel_i, data_i, data_o
//   gpio_i [GPIO_W]  asynchronous external inputs (two-flop synchronised)
//   gpio_o [GPIO_W]  registered GPIO_OUT
//   irq_o            timer interrupt, level
// -----------------------------------------------------------------------------
module data_bus
  import data_bus_pkg::*;
#(
  parameter int          RAM_AW    = 10,
  parameter int          GPIO_W    = 8,
  parameter logic [31:0] MMIO_BASE = {MMIO_NIBBLE, 28'h000_0000}
) (
  input  logic              clk,
  input  logic              rst,
  data_bus_if.slave         bus,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              irq_o
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic              bus_valid;
  target_e           target;
  logic [RAM_AW-1:0] ram_idx;
  logic [7:0]        mmio_offset;
  logic              ram_we;
  logic              mmio_wr;

  assign bus_valid   = |bus.ce_i;
  assign ram_idx     = bus.addr_i[RAM_AW+1:2];
  assign mmio_offset = bus.addr_i[7:0];

  always_comb begin
    target = TGT_NONE;
    if (bus_valid) begin
      target = addr_is_mmio(bus.addr_i, MMIO_BASE[31:28]) ? TGT_MMIO : TGT_RAM;
    end
  end

  // Reset drops any write presented in the same cycle, RAM included
  assign ram_we  = (target == TGT_RAM) && bus.we_i && !rst;
  // MMIO registers only accept full-word writes
  assign mmio_wr = (target == TGT_MMIO) && bus.we_i && (bus.sel_i == 4'b1111);

  // Address bits that alias (above the RAM index) and the byte offset
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[27:RAM_AW+2], bus.addr_i[1:0]};

  // ---------------------------------------------------------------------------
  // Data RAM: one byte-wide array per lane so each lane has its own write
  // enable; read is asynchronous to meet the same-cycle MEM-stage sample.
  // Contents are deliberately not cleared by rst.
  // ---------------------------------------------------------------------------
  logic [3:0][7:0] ram_rdata;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
      if (ram_we && bus.sel_i[gi]) begin
        lane_mem[ram_idx] <= bus.data_i[gi*8 +: 8];
      end
    end

    assign ram_rdata[gi] = lane_mem[ram_idx];
  end

  // ---------------------------------------------------------------------------
  // Timer
  // ---------------------------------------------------------------------------
  logic [31:0] timer_rdata;

  data_bus_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (mmio_wr),
    .offset (mmio_offset),
    .wdata  (bus.data_i),
    .rdata  (timer_rdata),
    .irq    (irq_o)
  );

  // ---------------------------------------------------------------------------
  // GPIO: output register and two-flop input synchroniser
  // ---------------------------------------------------------------------------
  logic [GPIO_W-1:0] gpio_out_reg;
  logic [GPIO_W-1:0] gpio_sync1_reg;
  logic [GPIO_W-1:0] gpio_sync2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out_reg   <= '0;
      gpio_sync1_reg <= '0;
      gpio_sync2_reg <= '0;
    end else begin
      gpio_sync1_reg <= gpio_i;
      gpio_sync2_reg <= gpio_sync1_reg;
      if (mmio_wr && (mmio_offset == OFF_GPIO_OUT)) begin
        gpio_out_reg <= bus.data_i[GPIO_W-1:0];
      end
    end
  end

  assign gpio_o = gpio_out_reg;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [31:0] mmio_rdata;

  // Timer returns 0 for offsets it does not own, so GPIO just overrides
  always_comb begin
    mmio_rdata = timer_rdata;
    case (mmio_offset)
      OFF_GPIO_OUT: begin
        mmio_rdata = '0;
        mmio_rdata[GPIO_W-1:0] = gpio_out_reg;
      end
      OFF_GPIO_IN: begin
        mmio_rdata = '0;
        mmio_rdata[GPIO_W-1:0] = gpio_sync2_reg;
      end
      default: ;
    endcase
  end

  // Full word regardless of sel; 0 on writes and idle cycles
  always_comb begin
    bus.data_o = '0;
    if (!bus.we_i) begin
      case (target)
        TGT_RAM:  bus.data_o = ram_rdata;
        TGT_MMIO: bus.data_o = mmio_rdata;
        default:  bus.data_o = '0;
      endcase
    end
  end

endmodule
